ex_muldiv_seq: RTL and testbench
================================

Name: ex_muldiv_seq

Overview:
- Iterative sequencer for RV32M multiply/divide instructions in the EX stage of the pipelined OTTER.
- Accepts operands when an M-op reaches EX and holds the pipeline through stall until the result is ready.
- Presents the result for one cycle for EX/MEM capture.
- Honours flushes from the control-hazard unit.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  synchronous, active-high reset
- start  input  1  EX holds a valid M-extension op (level, held while stalled)
- flush  input  1  synchronous abort of the EX instruction (branch/jump taken)
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  XLEN  rs1 value (post-forwarding)
- op_b  input  XLEN  rs2 value (post-forwarding)
- stall  output  1  freeze PC/IF/ID/EX registers
- done  output  1  result valid this cycle
- result  output  XLEN  rd value

Behaviour:
- States: IDLE, RUN, DONE.
- Reset: state=IDLE; counter=0; done=0; result=0; stall=0. RST overrides every other input, including mid-RUN.
- stall is combinational: (IDLE & start & ~flush) | RUN. It is low in DONE so the pipeline advances.
- IDLE, start & ~flush:
  - Latch funct3, signedness, operand magnitudes (two's-complement abs when signed) and result-sign flags.
  - Clear the accumulator; counter=0; go to RUN.
- RUN:
  - Each cycle performs one step. Multiply: shift-add on a 2*XLEN product. Divide: restoring, one quotient bit per cycle with XLEN+1-bit partial remainder.
  - counter increments; after the XLEN-th step go to DONE.
- DONE:
  - done=1; result registered; the next state is always IDLE.
  - start seen in DONE is ignored (same instruction).
- Latency: start sampled at cycle N gives done at cycle N+XLEN+1 (N+33). Back-to-back M-ops restart from IDLE the cycle after DONE.
- Sign rules:
  - MUL/MULH: both operands signed. MULHSU: A signed, B unsigned. MULHU/DIVU/REMU: unsigned.
  - Product negated when operand signs differ. MUL returns low XLEN; MULH* return high XLEN.
  - Quotient negated when signs differ; remainder takes the dividend's sign.
- Divide by zero: quotient sign correction is suppressed. DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a unchanged.
- Overflow DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM gives 0. These fall out of the 33-bit datapath with no special case.
- flush:
  - Flush in any state: next state=IDLE, no done, result unchanged.
  - flush with start in IDLE: no launch, stall=0.
- result holds its last value when done=0.

Optional Feature:
- Macro: MULDIV_FASTZERO_EN.
- Defined: when the latched op_b==0 (any funct3) or op_a==0 for multiplies, IDLE goes directly to DONE. Zero-case results are computed directly, done at N+1, and stall is high only in cycle N.
- Undefined: all ops take the full XLEN iterations; results are identical.

Decomposition:
- Shared package otter_muldiv_pkg holds:
  - muldiv_state_t enum (IDLE, RUN, DONE).
  - funct3 localparams (F3_MUL … F3_REMU).
  - MULDIV_ITERS = XLEN.
- One sub-module, muldiv_sign_adj: combinational conditional two's-complement negate, used for operand abs and for result fix-up.

Test Plan:
- MUL 7 × 0xFFFFFFFD at cycle N -> stall high cycles N..N+32, done at N+33, result 0xFFFFFFEB.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU -> 2.
- DIV 5 / 0 -> 0xFFFFFFFF. REMU 5 / 0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. With MULDIV_FASTZERO_EN, the divide-by-zero cases give done at N+1.
- flush at RUN cycle 10 -> stall low next cycle, no done. A new DIVU 9 / 3 then returns 3 at its start+33.
- RST asserted mid-RUN -> next cycle state IDLE, stall=0, done=0, result=0. Two back-to-back MULs -> second done exactly 34 cycles after first.

Source files
------------

// File: rtl/otter_muldiv_pkg.sv
// Shared types and constants for the OTTER EX-stage RV32M multiply/divide sequencer.
package otter_muldiv_pkg;

  localparam int MULDIV_XLEN  = 32;
  localparam int MULDIV_ITERS = MULDIV_XLEN;

  typedef enum logic [1:0] {IDLE, RUN, DONE} muldiv_state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Per-instruction context captured at launch.
  typedef struct packed {
    logic [2:0] f3;
    logic       res_neg;
  } muldiv_ctx_t;

  function automatic logic a_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_adj.sv
// Conditional two's-complement negate: operand magnitude and result sign fix-up.
module muldiv_sign_adj #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  assign dout = neg ? -din : din;
endmodule

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the OTTER EX stage (shift-add / restoring).
// Optional MULDIV_FASTZERO_EN: zero-operand cases finish one cycle after launch.
module ex_muldiv_seq
  import otter_muldiv_pkg::*;
#(
  parameter int XLEN = MULDIV_XLEN
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);

  muldiv_state_t   state, nstate;
  muldiv_ctx_t     ctx;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi, lo, ma, mb;
  logic [XLEN-1:0] abs_a, abs_b, hi_n, lo_n, fin_sel;
  logic [XLEN:0]   sum, sh, diff;
  logic [2*XLEN-1:0] fin_raw, fin;
  logic [2:0]      f;
  logic            sa, sb, launch, launch_neg, fast, fin_neg, last;

  assign sa     = op_a[XLEN-1] & a_signed(funct3);
  assign sb     = op_b[XLEN-1] & b_signed(funct3);
  assign launch = (state == IDLE) && start && !flush;
  assign last   = (cnt == CW'(XLEN-1));

  muldiv_sign_adj #(.W(XLEN))   u_abs_a (.neg(sa), .din(op_a), .dout(abs_a));
  muldiv_sign_adj #(.W(XLEN))   u_abs_b (.neg(sb), .din(op_b), .dout(abs_b));
  muldiv_sign_adj #(.W(2*XLEN)) u_fix   (.neg(fin_neg), .din(fin_raw), .dout(fin));

`ifdef MULDIV_FASTZERO_EN
  assign fast = (op_b == '0) || (!funct3[2] && (op_a == '0));
`else
  assign fast = 1'b0;
`endif

  // Divide-by-zero never flips the quotient; the remainder follows the dividend.
  always_comb begin
    if (funct3[2]) launch_neg = funct3[1] ? sa : ((sa ^ sb) && (op_b != '0));
    else           launch_neg = sa ^ sb;
  end

  // One iteration: hi/lo are product-high/multiplier for mul, remainder/quotient for div.
  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, ma} : '0);
    sh   = {hi, lo[XLEN-1]};
    diff = sh - {1'b0, mb};
    if (ctx.f3[2]) begin
      hi_n = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], ~diff[XLEN]};
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo[XLEN-1:1]};
    end
  end

  always_comb begin
    f       = (state == IDLE) ? funct3 : ctx.f3;
    fin_raw = '0;
    fin_neg = 1'b0;
    if (state == IDLE) begin
      if (funct3[2]) begin
        fin_raw = funct3[1] ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, {XLEN{1'b1}}};
        fin_neg = funct3[1] & sa;
      end
    end else if (ctx.f3[2]) begin
      fin_raw = {{XLEN{1'b0}}, (ctx.f3[1] ? hi_n : lo_n)};
      fin_neg = ctx.res_neg;
    end else begin
      fin_raw = {hi_n, lo_n};
      fin_neg = ctx.res_neg;
    end
    fin_sel = (!f[2] && (f[1:0] != 2'b00)) ? fin[2*XLEN-1:XLEN] : fin[XLEN-1:0];
  end

  always_comb begin
    nstate = state;
    stall  = 1'b0;
    done   = 1'b0;
    case (state)
      IDLE: if (launch) begin
        stall  = 1'b1;
        nstate = fast ? DONE : RUN;
      end
      RUN: begin
        stall = 1'b1;
        if (flush)     nstate = IDLE;
        else if (last) nstate = DONE;
      end
      DONE: begin
        done   = !flush;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
      hi     <= '0;
      lo     <= '0;
      ma     <= '0;
      mb     <= '0;
      ctx    <= '0;
    end else begin
      state <= nstate;
      if (launch) begin
        ctx    <= '{f3: funct3, res_neg: launch_neg};
        ma     <= abs_a;
        mb     <= abs_b;
        hi     <= '0;
        lo     <= funct3[2] ? abs_a : abs_b;
        cnt    <= '0;
        if (fast) result <= fin_sel;
      end else if (state == RUN && !flush) begin
        hi  <= hi_n;
        lo  <= lo_n;
        cnt <= cnt + CW'(1);
        if (last) result <= fin_sel;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq: arithmetic reference model plus per-cycle stall/done/result checks.
module tb_ex_muldiv_seq;
  logic        CLK = 1'b0;
  logic        RST, start, flush;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b, result;
  logic        stall, done;

  int n_assert = 0, n_fail = 0;
  int cyc = 0;

  bit          mon_en = 0, pend = 0;
  int          n0, lat;
  logic [31:0] exp_val, last_res;

  ex_muldiv_seq #(.XLEN(32)) dut (
    .CLK(CLK), .RST(RST), .start(start), .flush(flush), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .stall(stall), .done(done), .result(result)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Reference results straight from the RV32M arithmetic definitions.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa_l, sb_l, ua, ub, p;
    longint unsigned pu;
    sa_l = longint'($signed(a));
    sb_l = longint'($signed(b));
    ua   = longint'({32'b0, a});
    ub   = longint'({32'b0, b});
    case (f)
      3'd0: begin p = sa_l * sb_l; return p[31:0];  end
      3'd1: begin p = sa_l * sb_l; return p[63:32]; end
      3'd2: begin p = sa_l * ub;   return p[63:32]; end
      3'd3: begin pu = ua * ub;    return pu[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa_l / sb_l; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub;     return p[31:0]; end
      3'd6: begin if (b == 0) return a;             p = sa_l % sb_l; return p[31:0]; end
      default: begin if (b == 0) return a;          p = ua % ub;     return p[31:0]; end
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FASTZERO_EN
    if (b == 0 || (!f[2] && a == 0)) return 1;
`endif
    return 33;
  endfunction

  // Per-cycle compare against the timing/value model.
  always @(negedge CLK) if (mon_en) begin
    bit es, ed;
    es = pend && ((cyc == n0 && !flush) || (cyc > n0 && cyc < n0 + lat));
    ed = pend && (cyc == n0 + lat) && !flush;
    chk("stall", {31'b0, stall}, {31'b0, es});
    chk("done",  {31'b0, done},  {31'b0, ed});
    if (ed) last_res = exp_val;
    chk("result", result, last_res);
    if (ed || (pend && flush) || RST) pend = 0;
    if (RST) last_res = '0;
  end

  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    n0 = cyc; lat = lat_of(f, a, b); exp_val = model(f, a, b); pend = 1;
  endtask

  // Called #1 after a rising edge; returns #1 after the edge following done.
  task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] want, output int dcyc);
    int s;
    chk({nm, "_model"}, model(f, a, b), want);
    launch(f, a, b);
    s = cyc;
    dcyc = -1;
    for (int k = 0; k < 40 && dcyc < 0; k++) begin
      @(negedge CLK);
      if (done) begin
        dcyc = cyc;
        chk(nm, result, want);
      end
    end
    if (dcyc < 0) begin
      n_assert++; n_fail++;
      $display("FAIL %s_timeout: no done within 40 cycles of cycle %0d", nm, s);
    end else begin
      chk({nm, "_lat"}, dcyc - s, lat_of(f, a, b));
    end
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  initial begin
    int d1, d2, dd;
    RST = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    last_res = '0;
    tick(3);
    RST = 1'b0;
    mon_en = 1;
    @(negedge CLK);
    chk("reset_result", result, 32'h0);
    chk("reset_stall", {31'b0, stall}, 32'h0);
    tick(1);

    do_op("mul_neg",    3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, dd);
    tick(2);
    do_op("mulh_min",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, dd);
    do_op("mulhu_max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, dd);
    do_op("mulhsu",     3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, dd);
    do_op("div_neg",    3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, dd);
    do_op("rem_neg",    3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, dd);
    do_op("divu",       3'd5, 32'd100,       32'd7,         32'd14,        dd);
    do_op("remu",       3'd7, 32'd100,       32'd7,         32'd2,         dd);
    do_op("div_zero",   3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, dd);
    do_op("remu_zero",  3'd7, 32'd5,         32'd0,         32'd5,         dd);
    do_op("div_nzero",  3'd4, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, dd);
    do_op("rem_nzero",  3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, dd);
    do_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, dd);
    do_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         dd);
    do_op("mul_zero",   3'd0, 32'd0,         32'd12345,     32'h0,         dd);
    tick(1);

    // Flush on the tenth RUN cycle: pipeline released, no done.
    launch(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    tick(10);
    flush = 1'b1;
    tick(1);
    flush = 1'b0; start = 1'b0;
    tick(40);
    do_op("divu_after_flush", 3'd5, 32'd9, 32'd3, 32'd3, dd);

    // Flush coincident with start in IDLE: nothing launches.
    launch(3'd0, 32'd3, 32'd3);
    flush = 1'b1;
    tick(1);
    flush = 1'b0; start = 1'b0;
    tick(40);

    // Back-to-back: second op launches the cycle after the first done.
    do_op("b2b_first",  3'd0, 32'd3,         32'd4, 32'd12,        d1);
    do_op("b2b_second", 3'd0, 32'hFFFF_FFFE, 32'd6, 32'hFFFF_FFF4, d2);
    chk("b2b_spacing", d2 - d1, 34);

    // Reset mid-RUN.
    tick(1);
    launch(3'd4, 32'd1000, 32'd7);
    tick(6);
    RST = 1'b1; start = 1'b0;
    tick(1);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_mid_result", result, 32'h0);
    chk("rst_mid_stall", {31'b0, stall}, 32'h0);
    chk("rst_mid_done", {31'b0, done}, 32'h0);
    tick(40);

    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
